// File: rtl/clockdiv_pkg.sv
// Shared types and helpers for the tick-driven timer scheduler and its arbiter.
package clockdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;
  localparam int MAX_N = 8;

  function automatic logic [MAX_N-1:0] to_onehot(input logic [2:0] idx);
    to_onehot = 8'd1 << idx;
  endfunction

endpackage

// File: rtl/tick_timer_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester with req high, searching
// upward from pointer+1 with wrap-around.
module rr_arbiter
  import clockdiv_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  select,
  output logic [IW-1:0] index
);

  logic found;
  int   cand;

  // Priority scan starting just after the last winner
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(pointer) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      if (!found && req[IW'(cand)]) begin
        found = 1'b1;
        index = IW'(cand);
      end else begin
        found = found;
      end
    end
  end

  // One-hot view of the winner, all-zero when nobody requests
  always_comb begin
    if (found) begin
      select = N'(to_onehot(3'(index)));
    end else begin
      select = '0;
    end
  end

endmodule

// File: rtl/tick_timer_scheduler.sv
// One shared tick-driven countdown timer, handed out round-robin to N requesters;
// each job counts its own duration in ticks and ends with a one-cycle done pulse.
module tick_timer_scheduler
  import clockdiv_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           tick,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] dur,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   remaining
);

  localparam int IW = $clog2(N);

  sched_state_t  state_r;
  sched_state_t  state_s;
  logic [IW-1:0] pointer_r;
  logic [IW-1:0] pointer_s;
  logic [N-1:0]  grant_s;
  logic [N-1:0]  done_s;
  logic          busy_s;
  logic [W-1:0]  remaining_s;
  logic [N-1:0]  arb_select_s;
  logic [IW-1:0] arb_index_s;
  logic [W-1:0]  sel_dur_s;

  rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .pointer (pointer_r),
    .select  (arb_select_s),
    .index   (arb_index_s)
  );

  // Duration of the arbitration winner, masked by its one-hot select
  always_comb begin
    sel_dur_s = '0;
    for (int i = 0; i < N; i++) begin
      sel_dur_s = sel_dur_s | (dur[i*W +: W] & {W{arb_select_s[i]}});
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    pointer_s   = pointer_r;
    grant_s     = grant;
    done_s      = '0;
    busy_s      = busy;
    remaining_s = remaining;
    case (state_r)
      IDLE: begin
        grant_s     = '0;
        busy_s      = 1'b0;
        remaining_s = '0;
        if (|req) begin
          pointer_s = arb_index_s;
          busy_s    = 1'b1;
          // A zero-length job skips RUN and reports completion immediately
          if (sel_dur_s == '0) begin
            state_s = DONE;
            done_s  = arb_select_s;
          end else begin
            state_s     = RUN;
            grant_s     = arb_select_s;
            remaining_s = sel_dur_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // Cancel takes precedence over a coincident final tick
        if (!req[pointer_r]) begin
          state_s     = IDLE;
          grant_s     = '0;
          busy_s      = 1'b0;
          remaining_s = '0;
        end else if (tick) begin
          if (remaining == W'(1)) begin
            state_s     = DONE;
            grant_s     = '0;
            remaining_s = '0;
            done_s      = N'(to_onehot(3'(pointer_r)));
          end else begin
            remaining_s = remaining - W'(1);
          end
        end else begin
          remaining_s = remaining;
        end
      end
      DONE: begin
        state_s     = IDLE;
        grant_s     = '0;
        busy_s      = 1'b0;
        remaining_s = '0;
      end
      default: begin
        state_s     = IDLE;
        grant_s     = '0;
        busy_s      = 1'b0;
        remaining_s = '0;
      end
    endcase
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r   <= IDLE;
      pointer_r <= IW'(N - 1);
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      state_r   <= state_s;
      pointer_r <= pointer_s;
      grant     <= grant_s;
      done      <= done_s;
      busy      <= busy_s;
      remaining <= remaining_s;
    end
  end

endmodule
